ddr3_rd_line_fetch: RTL
=======================

Name: ddr3_rd_line_fetch

Overview:
- Read-side consumer of the DDR3 ping-pong frame buffer.
- On each frame start it issues one single-cycle read request per burst to the DDR3 read-address generator, for every request block of every PWM subframe.
- It tags each returned read beat with subframe, half (up/down), row and beat, and streams it to the display line buffers.
- Flow control comes from an outstanding-read cap and a downstream almost-full.

Parameters:
- DATA_W, 256, width of one DDR3 read beat (cache width)
- LINE_TRANS_NUM, 4, bursts per display row
- REQ_ROW, 2, rows per request block; must be even
- CHIP_RES_ROW, 8, rows per subframe; must be a multiple of REQ_ROW
- PWM_NUM, 19, subframes per frame
- MAX_OUTSTANDING, 16, maximum issued-but-unreturned requests

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- frame_start  in  1  single-cycle pulse; starts fetch of one full frame
- dout_afull  in  1  downstream line buffer almost full
- rd_valid  in  1  read beat returned from DDR3
- rd_data  in  DATA_W  read beat data
- req_o  out  1  one-cycle read request, one per burst
- busy  out  1  high from accepted frame_start until frame_done
- dout_valid  out  1  tagged beat valid
- dout_data  out  DATA_W  beat data
- dout_half  out  1  0 = up half of block, 1 = down half
- dout_row  out  clog2(CHIP_RES_ROW)  absolute row within subframe
- dout_beat  out  clog2(LINE_TRANS_NUM)  burst index within row
- dout_sf  out  clog2(PWM_NUM)  subframe index
- frame_done  out  1  one-cycle pulse after last beat delivered
- err_frame_overrun  out  1  sticky
- err_unexpected  out  1  sticky

Behaviour:
- Reset state: all outputs 0, all counters 0, FSM in IDLE.
- Derived constants:
  - REQ_ONCE_CNT = LINE_TRANS_NUM*REQ_ROW
  - HALF = REQ_ONCE_CNT/2
  - REQ_CNT = CHIP_RES_ROW/REQ_ROW
  - BLK_TOTAL = REQ_CNT*PWM_NUM
  - REQ_TOTAL = BLK_TOTAL*REQ_ONCE_CNT
- FSM states: IDLE, REQ, DRAIN.
  - IDLE -> REQ on frame_start; busy is set the next cycle.
  - REQ -> DRAIN in the cycle the REQ_TOTAL-th req_o is registered.
  - DRAIN -> IDLE when returned count reaches REQ_TOTAL; frame_done pulses in the same cycle as the last dout_valid + 1, and busy clears the same cycle.
- Issue rule (req_o is registered): req_o is asserted at edge n+1 iff all of the following hold at edge n:
  - state is REQ and issued < REQ_TOTAL;
  - dout_afull is 0;
  - outstanding_next < MAX_OUTSTANDING.
  - This gives back-to-back requests when unconstrained.
- Outstanding counter:
  - Increments on req_o and decrements on rd_valid; simultaneous events leave it unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - Width is clog2(MAX_OUTSTANDING+1).
- Response tagging uses counter rsp_in_blk (0..REQ_ONCE_CNT-1) and block counter blk (0..BLK_TOTAL-1), both advancing on accepted rd_valid:
  - half = rsp_in_blk >= HALF
  - beat = rsp_in_blk mod LINE_TRANS_NUM
  - row = (blk mod REQ_CNT)*REQ_ROW + half*(REQ_ROW/2) + (rsp_in_blk mod HALF)/LINE_TRANS_NUM
  - sf = blk / REQ_CNT, kept as a separate wrap counter; no divider.
  - rsp_in_blk wraps at REQ_ONCE_CNT-1, which increments blk.
- dout_* are registered: 1-cycle latency from rd_valid, and data is unmodified.
- Boundary conditions:
  - frame_start while busy: ignored; err_frame_overrun is set.
  - rd_valid while outstanding==0: beat dropped, no dout_valid, err_unexpected is set.
  - dout_afull rising: at most one further req_o follows (the pipeline register).
  - The return path is never back-pressured; downstream must size its afull margin ≥ MAX_OUTSTANDING+1.
  - rst asserted mid-frame: immediate return to reset state; in-flight returns arriving after reset count as unexpected.
- Error flags are cleared only by rst.

Decomposition:
- Shared package holds the derived constants (REQ_ONCE_CNT, HALF, REQ_CNT, BLK_TOTAL, REQ_TOTAL) and the FSM state enum. These are the same constants used by the read-address generator, so the two cannot diverge.
- One sub-module, ddr3_rd_tag_cnt: the rsp_in_blk/blk/row-group/sf counter chain producing half/row/beat/sf. It is reusable for the write side.

Test Plan (defaults: REQ_ONCE_CNT=8, BLK_TOTAL=76, REQ_TOTAL=608):
1. Reset, then idle for 20 cycles -> all outputs 0, no req_o.
2. frame_start; responder returns rd_valid 3 cycles after each req_o; dout_afull=0 -> exactly 608 req_o and 608 dout_valid.
   - Beats 0-3 tag half0/row0/beat0..3; beats 4-7 tag half1/row1; beat 8 tags row2/sf0; beat 32 tags sf1/row0.
   - frame_done pulses once; busy then falls.
3. rd_valid held low after frame_start -> exactly 16 req_o, then stall. One rd_valid -> exactly one more req_o.
4. dout_afull raised mid-frame for 50 cycles -> at most 1 req_o after the rise and none during the remainder. The frame still totals 608 requests.
5. Second frame_start while busy -> err_frame_overrun=1; request and beat totals are still 608.
6. rd_valid in IDLE -> err_unexpected=1, no dout_valid. Then rst mid-frame at request 100 -> all outputs 0 next cycle; a new frame_start completes normally with 608 beats.

Source files
------------

// File: rtl/ddr3_rd_line_fetch_pkg.sv
// Purpose: frame geometry and FSM encoding shared by the DDR3 read-side blocks.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: geometry constants, derived request counts, counter widths, fetch FSM state enum.
package ddr3_rd_line_fetch_pkg;

  // Frame geometry (shared with the DDR3 read-address generator)
  localparam int LINE_TRANS_NUM = 4;   // bursts per display row
  localparam int REQ_ROW        = 2;   // rows per request block (even)
  localparam int CHIP_RES_ROW   = 8;   // rows per subframe (multiple of REQ_ROW)
  localparam int PWM_NUM        = 19;  // subframes per frame

  // Derived request counts
  localparam int REQ_ONCE_CNT = LINE_TRANS_NUM * REQ_ROW;   // beats per request block
  localparam int HALF         = REQ_ONCE_CNT / 2;           // beats per half block
  localparam int REQ_CNT      = CHIP_RES_ROW / REQ_ROW;     // blocks per subframe
  localparam int BLK_TOTAL    = REQ_CNT * PWM_NUM;          // blocks per frame
  localparam int REQ_TOTAL    = BLK_TOTAL * REQ_ONCE_CNT;   // requests per frame

  // Keeps single-value counters at least one bit wide.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int ROW_W  = clog2_min1(CHIP_RES_ROW);
  localparam int BEAT_W = clog2_min1(LINE_TRANS_NUM);
  localparam int SF_W   = clog2_min1(PWM_NUM);
  localparam int RSP_W  = clog2_min1(REQ_ONCE_CNT);
  localparam int GRP_W  = clog2_min1(REQ_CNT);
  localparam int TOT_W  = $clog2(REQ_TOTAL + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ddr3_rd_tag_cnt.sv
// Purpose: counter chain that tags each returned beat with half/row/beat/subframe.
// Latency: tags are combinational from the current counters; counters step on adv.
// Backpressure: none; advances once per adv pulse, wraps at end of frame.
// Ports: clk, rst (async high), clr (restart at frame start), adv (beat accepted),
//        half/row/beat/sf (tag for the beat presented in this cycle).
module ddr3_rd_tag_cnt
  import ddr3_rd_line_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  output logic              half,
  output logic [ROW_W-1:0]  row,
  output logic [BEAT_W-1:0] beat,
  output logic [SF_W-1:0]   sf
);

  localparam logic [RSP_W-1:0] RSP_LAST = RSP_W'(REQ_ONCE_CNT - 1);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(REQ_CNT - 1);
  localparam logic [SF_W-1:0]  SF_LAST  = SF_W'(PWM_NUM - 1);
  localparam logic [RSP_W-1:0] HALF_C   = RSP_W'(HALF);

  logic [RSP_W-1:0] rsp_in_blk;  // beat index within the request block
  logic [GRP_W-1:0] grp;         // block index within the subframe (blk mod REQ_CNT)

  // sf is its own wrap counter, carried from grp, so no divider is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_in_blk <= '0;
      grp        <= '0;
      sf         <= '0;
    end else if (clr) begin
      rsp_in_blk <= '0;
      grp        <= '0;
      sf         <= '0;
    end else if (adv) begin
      if (rsp_in_blk == RSP_LAST) begin
        rsp_in_blk <= '0;
        if (grp == GRP_LAST) begin
          grp <= '0;
          sf  <= (sf == SF_LAST) ? '0 : sf + 1'b1;
        end else begin
          grp <= grp + 1'b1;
        end
      end else begin
        rsp_in_blk <= rsp_in_blk + 1'b1;
      end
    end
  end

  // Moduli and divisors are all constants, so these reduce to bit selects
  // for power-of-two geometry.
  always_comb begin
    half = (rsp_in_blk >= HALF_C);
    beat = BEAT_W'(int'(rsp_in_blk) % LINE_TRANS_NUM);
    row  = ROW_W'(int'(grp) * REQ_ROW + (half ? REQ_ROW / 2 : 0)
                  + (int'(rsp_in_blk) % HALF) / LINE_TRANS_NUM);
  end

endmodule

// File: rtl/ddr3_rd_line_fetch.sv
// Purpose: per-frame DDR3 read requester; tags returned beats for the display line buffers.
// Latency: req_o registered; dout_* one cycle after rd_valid; frame_done one cycle after last beat.
// Backpressure: issue stalls on dout_afull or outstanding cap; the return path is never stalled.
// Ports: clk, rst (async high); frame_start, dout_afull, rd_valid/rd_data in;
//        req_o, busy, dout_valid/data/half/row/beat/sf, frame_done, sticky error flags out.
module ddr3_rd_line_fetch
  import ddr3_rd_line_fetch_pkg::*;
#(
  parameter int DATA_W          = 256,
  parameter int MAX_OUTSTANDING = 16
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              dout_afull,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              req_o,
  output logic              busy,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_half,
  output logic [ROW_W-1:0]  dout_row,
  output logic [BEAT_W-1:0] dout_beat,
  output logic [SF_W-1:0]   dout_sf,
  output logic              frame_done,
  output logic              err_frame_overrun,
  output logic              err_unexpected
);

  localparam int                 OUT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]   OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [TOT_W-1:0]   TOT_LAST = TOT_W'(REQ_TOTAL - 1);
  localparam logic [TOT_W-1:0]   TOT_ALL  = TOT_W'(REQ_TOTAL);

  fetch_state_t      state;
  logic [TOT_W-1:0]  issued;
  logic [TOT_W-1:0]  returned;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  out_next;
  logic              accept;
  logic              unexpected;
  logic              can_issue;
  logic              fs_accept;
  logic              tag_half;
  logic [ROW_W-1:0]  tag_row;
  logic [BEAT_W-1:0] tag_beat;
  logic [SF_W-1:0]   tag_sf;

  // A beat with nothing in flight cannot belong to this frame (e.g. it was
  // requested before a reset), so it is dropped rather than tagged.
  assign accept     = rd_valid && (outstanding != '0);
  assign unexpected = rd_valid && (outstanding == '0);
  assign fs_accept  = frame_start && (state == ST_IDLE);

  // req_o is the request registered last edge; it counts as in flight now.
  always_comb begin
    out_next = outstanding;
    if (req_o && !accept) begin
      out_next = outstanding + 1'b1;
    end else if (!req_o && accept) begin
      out_next = outstanding - 1'b1;
    end
  end

  // Deciding on out_next keeps the cap exact with back-to-back requests.
  assign can_issue = (state == ST_REQ) && (issued < TOT_ALL) && !dout_afull
                     && (out_next < OUT_MAX);

  ddr3_rd_tag_cnt u_tag (
    .clk  (clk),
    .rst  (rst),
    .clr  (fs_accept),
    .adv  (accept),
    .half (tag_half),
    .row  (tag_row),
    .beat (tag_beat),
    .sf   (tag_sf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      issued            <= '0;
      returned          <= '0;
      outstanding       <= '0;
      req_o             <= 1'b0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      dout_valid        <= 1'b0;
      dout_data         <= '0;
      dout_half         <= 1'b0;
      dout_row          <= '0;
      dout_beat         <= '0;
      dout_sf           <= '0;
      err_frame_overrun <= 1'b0;
      err_unexpected    <= 1'b0;
    end else begin
      outstanding <= out_next;
      req_o       <= can_issue;
      frame_done  <= 1'b0;
      dout_valid  <= accept;

      if (can_issue) issued <= issued + 1'b1;
      if (accept) begin
        returned  <= returned + 1'b1;
        dout_data <= rd_data;
        dout_half <= tag_half;
        dout_row  <= tag_row;
        dout_beat <= tag_beat;
        dout_sf   <= tag_sf;
      end

      if (frame_start && (state != ST_IDLE)) err_frame_overrun <= 1'b1;
      if (unexpected) err_unexpected <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            state    <= ST_REQ;
            busy     <= 1'b1;
            issued   <= '0;
            returned <= '0;
          end
        end
        ST_REQ: begin
          if (can_issue && (issued == TOT_LAST)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (returned == TOT_ALL) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
